// File: rtl/sh7604_pkg.sv
// ---------------------------------------------------------------------------
// sh7604_pkg
// Shared types and constants for the bus state controller refresh logic.
//   rfsh_state_e : refresh sequencer states
//   CKS_*        : RTCSR clock-select codes
//   cks_last()   : last prescaler count of a tick period for a given CKS
//                  (period - 1); returns 0 for CKS_OFF
// ---------------------------------------------------------------------------
package sh7604_pkg;

    typedef enum logic [2:0] {
        RF_IDLE  = 3'd0,
        RF_REQ   = 3'd1,
        RF_PRE   = 3'd2,
        RF_CAS   = 3'd3,
        RF_RAS   = 3'd4,
        RF_SELF  = 3'd5,
        RF_SEXIT = 3'd6
    } rfsh_state_e;

    localparam logic [2:0] CKS_OFF  = 3'b000;
    localparam logic [2:0] CKS_4    = 3'b001;
    localparam logic [2:0] CKS_16   = 3'b010;
    localparam logic [2:0] CKS_64   = 3'b011;
    localparam logic [2:0] CKS_256  = 3'b100;
    localparam logic [2:0] CKS_1024 = 3'b101;
    localparam logic [2:0] CKS_2048 = 3'b110;
    localparam logic [2:0] CKS_4096 = 3'b111;

    localparam logic [11:0] DIV_4_LAST    = 12'd3;
    localparam logic [11:0] DIV_16_LAST   = 12'd15;
    localparam logic [11:0] DIV_64_LAST   = 12'd63;
    localparam logic [11:0] DIV_256_LAST  = 12'd255;
    localparam logic [11:0] DIV_1024_LAST = 12'd1023;
    localparam logic [11:0] DIV_2048_LAST = 12'd2047;
    localparam logic [11:0] DIV_4096_LAST = 12'd4095;

    function automatic logic [11:0] cks_last(input logic [2:0] cks);
        logic [11:0] last;
        case (cks)
            CKS_4:    last = DIV_4_LAST;
            CKS_16:   last = DIV_16_LAST;
            CKS_64:   last = DIV_64_LAST;
            CKS_256:  last = DIV_256_LAST;
            CKS_1024: last = DIV_1024_LAST;
            CKS_2048: last = DIV_2048_LAST;
            CKS_4096: last = DIV_4096_LAST;
            default:  last = 12'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/rfsh_timer.sv
// ---------------------------------------------------------------------------
// rfsh_timer
// Refresh interval timer: 12-bit prescaler feeding the 8-bit RTCNT counter,
// compared against RTCOR. A compare match clears RTCNT and sets CMF.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ce_r                clock enable; counting and flag updates need ce_r=1
//   cks                 prescaler select (CKS_OFF stops ticks)
//   rtcor               compare value
//   rtcnt_we, rtcnt_di  counter write (wins over a tick, masks the compare)
//   cmf_clr             clear CMF (a match in the same cycle wins)
//   rtcnt, cmf          counter value and compare-match flag
//   match               one-cycle pulse on a compare match
// ---------------------------------------------------------------------------
module rfsh_timer
    import sh7604_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_r,
    input  logic [2:0] cks,
    input  logic [7:0] rtcor,
    input  logic       rtcnt_we,
    input  logic [7:0] rtcnt_di,
    input  logic       cmf_clr,
    output logic [7:0] rtcnt,
    output logic       cmf,
    output logic       match
);

    logic [11:0] presc;
    logic [2:0]  cks_q;
    logic        cks_chg;
    logic        tick;

    // cks_q follows CKS every clock so a select change is seen even while
    // ce_r is low; the change clears the prescaler instead of counting.
    assign cks_chg = (cks != cks_q);
    assign tick    = ce_r && (cks != CKS_OFF) && !cks_chg && (presc == cks_last(cks));
    assign match   = tick && !rtcnt_we && (rtcnt == rtcor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks_q <= CKS_OFF;
            presc <= 12'd0;
        end else begin
            cks_q <= cks;
            if (cks_chg || (ce_r && ((cks == CKS_OFF) || tick))) begin
                presc <= 12'd0;
            end else if (ce_r) begin
                presc <= presc + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtcnt <= 8'd0;
            cmf   <= 1'b0;
        end else if (ce_r) begin
            if (rtcnt_we) begin
                rtcnt <= rtcnt_di;
            end else if (match) begin
                rtcnt <= 8'd0;
            end else if (tick) begin
                rtcnt <= rtcnt + 8'd1;
            end

            if (match) begin
                cmf <= 1'b1;
            end else if (cmf_clr) begin
                cmf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bsc_rfsh_ctrl.sv
// ---------------------------------------------------------------------------
// bsc_rfsh_ctrl
// DRAM refresh controller of the bus state controller: interval timer,
// pending-refresh counter and the CBR / self-refresh bus sequencer.
// Ports:
//   CLK, RST_N, CE_R    clock, async active-low reset, rising-phase enable
//   CKS, CMIE           RTCSR clock select and compare-match irq enable
//   RFSH, RMODE         MCR refresh enable and mode (0 CBR, 1 self-refresh)
//   TRP, TRAS           MCR precharge (TRP+1) and RAS low (TRAS+2) cycles
//   RTCOR               compare value
//   RTCNT_WE/RTCNT_DI   counter write
//   CMF_CLR             clear compare-match flag
//   RFSH_GNT            bus grant (level)
//   RTCNT, CMF, IRQ     timer state and interrupt (CMF & CMIE)
//   RFSH_REQ            bus request, high only while waiting for the grant
//   RFSH_BUSY           refresh owns the bus
//   RFSH_RAS_N/CAS_N    refresh strobes
//   RFSH_DONE           one-CE_R pulse after a CBR cycle
// Handshake: RFSH_REQ is a level request held until a CE_R cycle sees
// RFSH_GNT=1; that cycle is the accept, and the bus cycle starts on the
// next state (PRE). Dropping RFSH while requesting withdraws the request.
// ---------------------------------------------------------------------------
module bsc_rfsh_ctrl
    import sh7604_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic [2:0] CKS,
    input  logic       CMIE,
    input  logic       RFSH,
    input  logic       RMODE,
    input  logic       TRP,
    input  logic [1:0] TRAS,
    input  logic [7:0] RTCOR,
    input  logic       RTCNT_WE,
    input  logic [7:0] RTCNT_DI,
    input  logic       CMF_CLR,
    input  logic       RFSH_GNT,
    output logic [7:0] RTCNT,
    output logic       CMF,
    output logic       IRQ,
    output logic       RFSH_REQ,
    output logic       RFSH_BUSY,
    output logic       RFSH_RAS_N,
    output logic       RFSH_CAS_N,
    output logic       RFSH_DONE
);

    rfsh_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        self_q, self_d;
    logic        done_q, done_d;
    logic [1:0]  pending_q;
    logic        match;
    logic        inc;
    logic        acc;
    logic [2:0]  trp_last;
    logic [2:0]  tras_last;

    rfsh_timer u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .ce_r     (CE_R),
        .cks      (CKS),
        .rtcor    (RTCOR),
        .rtcnt_we (RTCNT_WE),
        .rtcnt_di (RTCNT_DI),
        .cmf_clr  (CMF_CLR),
        .rtcnt    (RTCNT),
        .cmf      (CMF),
        .match    (match)
    );

    assign IRQ = CMF & CMIE;

    // Phase counters run 0..last, so a phase lasts last+1 cycles.
    assign trp_last  = {2'b00, TRP};
    assign tras_last = {1'b0, TRAS} + 3'd1;

    // Refresh owed on a CBR match; repaid when the grant is accepted in CBR mode.
    assign inc = match && RFSH && !RMODE;
    assign acc = (state_q == RF_REQ) && RFSH && RFSH_GNT && !RMODE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q <= 2'd0;
        end else if (CE_R) begin
            if (!RFSH) begin
                pending_q <= 2'd0;
            end else if (inc && !acc) begin
                if (pending_q != 2'd3) pending_q <= pending_q + 2'd1;
            end else if (acc && !inc) begin
                if (pending_q != 2'd0) pending_q <= pending_q - 2'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= RF_IDLE;
            cnt_q   <= 3'd0;
            self_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (CE_R) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            self_q  <= self_d;
            done_q  <= done_d;
        end
    end

    // The mode is latched at the grant so that RMODE changes mid-cycle
    // cannot redirect CAS between the CBR and self-refresh paths.
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        self_d  = self_q;
        done_d  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if ((!RMODE && (pending_q != 2'd0)) || (RFSH && RMODE)) state_d = RF_REQ;
            end
            RF_REQ: begin
                if (!RFSH) begin
                    state_d = RF_IDLE;
                end else if (RFSH_GNT) begin
                    state_d = RF_PRE;
                    self_d  = RMODE;
                end
            end
            RF_PRE: begin
                if (cnt_q == trp_last) state_d = RF_CAS;
                else                   cnt_d   = cnt_q + 3'd1;
            end
            RF_CAS: begin
                state_d = self_q ? RF_SELF : RF_RAS;
            end
            RF_RAS: begin
                if (cnt_q == tras_last) begin
                    state_d = RF_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RF_SELF: begin
                if (!(RFSH && RMODE)) state_d = RF_SEXIT;
            end
            RF_SEXIT: begin
                if (cnt_q == trp_last) state_d = RF_IDLE;
                else                   cnt_d   = cnt_q + 3'd1;
            end
            default: state_d = RF_IDLE;
        endcase
    end

    // Strobes decode the registered state only, so reset releases them
    // as soon as it clears the state register.
    always_comb begin
        RFSH_REQ   = (state_q == RF_REQ);
        RFSH_BUSY  = (state_q != RF_IDLE) && (state_q != RF_REQ);
        RFSH_RAS_N = !((state_q == RF_RAS) || (state_q == RF_SELF));
        RFSH_CAS_N = !((state_q == RF_CAS) || (state_q == RF_RAS) || (state_q == RF_SELF));
        RFSH_DONE  = done_q;
    end

endmodule

// File: tb/tb_bsc_rfsh_ctrl.sv
module tb_bsc_rfsh_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CE_R = 1'b0;
  logic [2:0] CKS = 3'd0;
  logic       CMIE = 1'b0;
  logic       RFSH = 1'b0;
  logic       RMODE = 1'b0;
  logic       TRP = 1'b0;
  logic [1:0] TRAS = 2'd0;
  logic [7:0] RTCOR = 8'd0;
  logic       RTCNT_WE = 1'b0;
  logic [7:0] RTCNT_DI = 8'd0;
  logic       CMF_CLR = 1'b0;
  logic       RFSH_GNT = 1'b0;
  logic [7:0] RTCNT;
  logic       CMF, IRQ, RFSH_REQ, RFSH_BUSY, RFSH_RAS_N, RFSH_CAS_N, RFSH_DONE;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  // bus view: {REQ, BUSY, RAS_N, CAS_N, DONE}
  localparam logic [4:0] V_IDLE  = 5'b00110;
  localparam logic [4:0] V_REQ   = 5'b10110;
  localparam logic [4:0] V_PRE   = 5'b01110;
  localparam logic [4:0] V_CAS   = 5'b01100;
  localparam logic [4:0] V_RAS   = 5'b01000;
  localparam logic [4:0] V_DONE  = 5'b00111;
  localparam logic [4:0] V_SELF  = 5'b01000;
  localparam logic [4:0] V_SEXIT = 5'b01110;

  bsc_rfsh_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CKS(CKS), .CMIE(CMIE),
    .RFSH(RFSH), .RMODE(RMODE), .TRP(TRP), .TRAS(TRAS), .RTCOR(RTCOR),
    .RTCNT_WE(RTCNT_WE), .RTCNT_DI(RTCNT_DI), .CMF_CLR(CMF_CLR),
    .RFSH_GNT(RFSH_GNT), .RTCNT(RTCNT), .CMF(CMF), .IRQ(IRQ),
    .RFSH_REQ(RFSH_REQ), .RFSH_BUSY(RFSH_BUSY), .RFSH_RAS_N(RFSH_RAS_N),
    .RFSH_CAS_N(RFSH_CAS_N), .RFSH_DONE(RFSH_DONE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    CE_R = 1'b0;
    RTCNT_WE = 1'b0;
    CMF_CLR = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step();
    step();
  endtask

  // ---------------- drivers / model helpers ----------------
  function automatic logic [4:0] bus_obs();
    return {RFSH_REQ, RFSH_BUSY, RFSH_RAS_N, RFSH_CAS_N, RFSH_DONE};
  endfunction

  function automatic int period_of(input int cks);
    case (cks)
      1: return 4;
      2: return 16;
      3: return 64;
      4: return 256;
      5: return 1024;
      6: return 2048;
      7: return 4096;
      default: return 0;
    endcase
  endfunction

  // Expected CE_R-cycle sequence of one CBR refresh.
  task automatic push_cbr(input bit with_req, input int trp, input int tras);
    if (with_req) exp_q.push_back(V_REQ);
    repeat (trp + 1) exp_q.push_back(V_PRE);
    exp_q.push_back(V_CAS);
    repeat (tras + 2) exp_q.push_back(V_RAS);
    exp_q.push_back(V_DONE);
  endtask

  // Leaves prescaler at 0, RTCNT=start, CMF=0, CE_R low.
  task automatic timer_setup(input logic [2:0] cks, input logic [7:0] rtcor, input logic [7:0] start);
    RTCOR = rtcor;
    CKS = 3'd0;
    CE_R = 1'b1;
    RTCNT_WE = 1'b1;
    RTCNT_DI = start;
    CMF_CLR = 1'b1;
    step();
    RTCNT_WE = 1'b0;
    CMF_CLR = 1'b0;
    CE_R = 1'b0;
    CKS = cks;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    CMIE = 1'b1;
    CKS = 3'd5;
    RFSH = 1'b1;
    RST_N = 1'b0;
    #3;
    checks++; if (RTCNT !== 8'd0) $display("FAIL reset_rtcnt: got %0h expected 0", RTCNT);
    if (RTCNT !== 8'd0) errors++;
    checks++; if (CMF !== 1'b0) begin errors++; $display("FAIL reset_cmf: got %0b expected 0", CMF); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b expected 0", IRQ); end
    checks++; if (bus_obs() !== V_IDLE) begin errors++; $display("FAIL reset_bus: got %05b expected %05b", bus_obs(), V_IDLE); end
  endtask

  task automatic test_basic_cbr();
    logic [4:0] e;
    RFSH = 1'b0;
    CKS = 3'd1; RTCOR = 8'd2; RMODE = 1'b0; RFSH_GNT = 1'b1;
    TRP = 1'b0; TRAS = 2'd0; CMIE = 1'b1;
    do_reset();
    RFSH = 1'b1;
    CE_R = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n >= 11) begin
        checks++;
        if (CMF !== 1'(n == 12)) begin errors++; $display("FAIL basic_cmf_at_%0d: got %0b expected %0b", n, CMF, (n == 12)); end
      end
    end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL basic_irq: got %0b expected 1", IRQ); end
    push_cbr(1, 0, 0);
    while (exp_q.size() > 0) begin
      if (exp_q.size() == 1) RFSH = 1'b0;
      step();
      e = exp_q.pop_front();
      checks++;
      if (bus_obs() !== e) begin errors++; $display("FAIL basic_bus: got %05b expected %05b", bus_obs(), e); end
    end
    step();
    checks++; if (bus_obs() !== V_IDLE) begin errors++; $display("FAIL basic_idle: got %05b expected %05b", bus_obs(), V_IDLE); end
  endtask

  task automatic test_pending_saturate();
    logic [4:0] e;
    int trp, tras;
    trp = $urandom_range(0, 1);
    tras = $urandom_range(0, 3);
    RFSH = 1'b0; RMODE = 1'b0; RFSH_GNT = 1'b0;
    TRP = 1'(trp); TRAS = 2'(tras);
    timer_setup(3'd1, 8'd0, 8'd0);
    CE_R = 1'b1;
    RFSH = 1'b1;
    repeat (18) step();  // four matches, no grant
    CKS = 3'd0;
    step();
    checks++; if (bus_obs() !== V_REQ) begin errors++; $display("FAIL sat_waiting: got %05b expected %05b", bus_obs(), V_REQ); end
    RFSH_GNT = 1'b1;
    push_cbr(0, trp, tras);
    push_cbr(1, trp, tras);
    push_cbr(1, trp, tras);
    repeat (4) exp_q.push_back(V_IDLE);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (bus_obs() !== e) begin errors++; $display("FAIL sat_bus: got %05b expected %05b", bus_obs(), e); end
    end
    RFSH = 1'b0;
    RFSH_GNT = 1'b0;
  endtask

  task automatic test_we_cmf();
    RFSH = 1'b0; CMIE = 1'b1;
    timer_setup(3'd1, 8'd5, 8'd3);
    CE_R = 1'b1;
    repeat (3) step();
    checks++; if (RTCNT !== 8'd3) begin errors++; $display("FAIL we_pre: got %0h expected 3", RTCNT); end
    RTCNT_WE = 1'b1; RTCNT_DI = 8'd5;   // lands on the tick, equals RTCOR
    step();
    RTCNT_WE = 1'b0;
    checks++; if (RTCNT !== 8'd5) begin errors++; $display("FAIL we_value: got %0h expected 5", RTCNT); end
    checks++; if (CMF !== 1'b0) begin errors++; $display("FAIL we_no_cmf: got %0b expected 0", CMF); end
    repeat (3) step();
    CMF_CLR = 1'b1;                    // next tick matches
    step();
    checks++; if (CMF !== 1'b1) begin errors++; $display("FAIL clr_vs_match: got %0b expected 1", CMF); end
    checks++; if (RTCNT !== 8'd0) begin errors++; $display("FAIL match_clears: got %0h expected 0", RTCNT); end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL match_irq: got %0b expected 1", IRQ); end
    step();
    CMF_CLR = 1'b0;
    checks++; if (CMF !== 1'b0) begin errors++; $display("FAIL clr: got %0b expected 0", CMF); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL clr_irq: got %0b expected 0", IRQ); end
    timer_setup(3'd1, 8'h10, 8'hFF);
    CE_R = 1'b1;
    repeat (4) step();
    checks++; if (RTCNT !== 8'd0) begin errors++; $display("FAIL wrap_value: got %0h expected 0", RTCNT); end
    checks++; if (CMF !== 1'b0) begin errors++; $display("FAIL wrap_no_cmf: got %0b expected 0", CMF); end
  endtask

  task automatic test_self_refresh();
    logic [4:0] e;
    int trp, k;
    trp = $urandom_range(0, 1);
    k = $urandom_range(3, 8);
    RFSH = 1'b0; RMODE = 1'b1; CKS = 3'd0; RFSH_GNT = 1'b1; TRP = 1'(trp);
    do_reset();
    CE_R = 1'b1;
    RFSH = 1'b1;
    exp_q.push_back(V_REQ);
    repeat (trp + 1) exp_q.push_back(V_PRE);
    exp_q.push_back(V_CAS);
    repeat (k) exp_q.push_back(V_SELF);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (bus_obs() !== e) begin errors++; $display("FAIL self_enter: got %05b expected %05b", bus_obs(), e); end
    end
    RMODE = 1'b0;
    repeat (trp + 1) exp_q.push_back(V_SEXIT);
    repeat (3) exp_q.push_back(V_IDLE);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (bus_obs() !== e) begin errors++; $display("FAIL self_exit: got %05b expected %05b", bus_obs(), e); end
    end
    RFSH = 1'b0;
  endtask

  task automatic test_random_cbr();
    logic [4:0] last;
    int trp, tras, d, popped;
    for (int it = 0; it < 6; it++) begin
      RFSH = 1'b0; RMODE = 1'b0; RFSH_GNT = 1'b0;
      trp = $urandom_range(0, 1);
      tras = $urandom_range(0, 3);
      TRP = 1'(trp); TRAS = 2'(tras);
      timer_setup(3'd1, 8'd0, 8'd0);
      CE_R = 1'b1;
      RFSH = 1'b1;
      repeat (4) step();                // one match
      CKS = 3'd0;
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        step();
        checks++;
        if (bus_obs() !== V_REQ) begin errors++; $display("FAIL rnd_req_wait: got %05b expected %05b", bus_obs(), V_REQ); end
      end
      RFSH_GNT = 1'b1;
      push_cbr(0, trp, tras);
      last = V_REQ;
      popped = 0;
      while (exp_q.size() > 0) begin
        if (exp_q.size() == 1) begin
          RFSH = 1'b0; RMODE = 1'b0; CE_R = 1'b1;
        end else if (popped > 0) begin
          RFSH = 1'($urandom_range(0, 1));
          RMODE = 1'($urandom_range(0, 1));
          CE_R = ($urandom_range(0, 2) != 0);
        end
        step();
        if (CE_R) begin
          last = exp_q.pop_front();
          popped++;
        end
        checks++;
        if (bus_obs() !== last) begin errors++; $display("FAIL rnd_cbr_bus: got %05b expected %05b", bus_obs(), last); end
      end
      CE_R = 1'b1;
      repeat (3) begin
        step();
        checks++;
        if (bus_obs() !== V_IDLE) begin errors++; $display("FAIL rnd_cbr_idle: got %05b expected %05b", bus_obs(), V_IDLE); end
      end
    end
    RFSH_GNT = 1'b0;
  endtask

  task automatic test_reset_mid_ras();
    bit found;
    found = 1'b0;
    RFSH = 1'b0; RMODE = 1'b0;
    timer_setup(3'd1, 8'd0, 8'd0);
    TRP = 1'b1; TRAS = 2'd3; RFSH_GNT = 1'b1;
    RFSH = 1'b1;
    CE_R = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (RFSH_RAS_N === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL ras_timeout: got no RAS in 40 cycles expected RAS low"); end
    #2;
    RST_N = 1'b0;
    CKS = 3'd0;
    #1;
    checks++; if (RFSH_RAS_N !== 1'b1) begin errors++; $display("FAIL async_ras_n: got %0b expected 1", RFSH_RAS_N); end
    checks++; if (RFSH_CAS_N !== 1'b1) begin errors++; $display("FAIL async_cas_n: got %0b expected 1", RFSH_CAS_N); end
    checks++; if (RFSH_BUSY !== 1'b0) begin errors++; $display("FAIL async_busy: got %0b expected 0", RFSH_BUSY); end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus_obs() !== V_IDLE) begin errors++; $display("FAIL post_reset_idle: got %05b expected %05b", bus_obs(), V_IDLE); end
    end
    checks++; if (RTCNT !== 8'd0) begin errors++; $display("FAIL post_reset_rtcnt: got %0h expected 0", RTCNT); end
    RFSH = 1'b0;
    RFSH_GNT = 1'b0;
  endtask

  task automatic test_random_timer();
    int per, m_phase, cks;
    logic [7:0] m_cnt, rtcor;
    logic m_cmf, tick, hit;
    RFSH = 1'b0;
    for (int r = 0; r < 4; r++) begin
      cks = $urandom_range(1, 3);
      rtcor = 8'($urandom_range(0, 6));
      m_cnt = 8'($urandom_range(0, 8));
      CMIE = 1'($urandom_range(0, 1));
      timer_setup(3'(cks), rtcor, m_cnt);
      m_cmf = 1'b0;
      m_phase = 0;
      per = period_of(cks);
      for (int i = 0; i < 600; i++) begin
        CE_R = ($urandom_range(0, 3) != 0);
        RTCNT_WE = ($urandom_range(0, 49) == 0);
        RTCNT_DI = 8'($urandom_range(0, 10));
        CMF_CLR = ($urandom_range(0, 15) == 0);
        if (CE_R) begin
          tick = 1'b0;
          hit = 1'b0;
          m_phase++;
          if (m_phase == per) begin
            tick = 1'b1;
            m_phase = 0;
          end
          if (RTCNT_WE) m_cnt = RTCNT_DI;
          else if (tick) begin
            if (m_cnt == rtcor) begin
              m_cnt = 8'd0;
              hit = 1'b1;
            end else begin
              m_cnt = m_cnt + 8'd1;
            end
          end
          if (hit) m_cmf = 1'b1;
          else if (CMF_CLR) m_cmf = 1'b0;
        end
        step();
        checks++; if (RTCNT !== m_cnt) begin errors++; $display("FAIL rnd_rtcnt: got %0h expected %0h", RTCNT, m_cnt); end
        checks++; if (CMF !== m_cmf) begin errors++; $display("FAIL rnd_cmf: got %0b expected %0b", CMF, m_cmf); end
        checks++; if (IRQ !== (m_cmf & CMIE)) begin errors++; $display("FAIL rnd_irq: got %0b expected %0b", IRQ, m_cmf & CMIE); end
      end
      RTCNT_WE = 1'b0;
      CMF_CLR = 1'b0;
    end
  endtask

  task automatic test_cks_zero();
    RFSH = 1'b0;
    timer_setup(3'd0, 8'h5A, 8'h5A);
    CE_R = 1'b1;
    repeat (10000) step();
    checks++; if (RTCNT !== 8'h5A) begin errors++; $display("FAIL cks0_rtcnt: got %0h expected 5a", RTCNT); end
    checks++; if (CMF !== 1'b0) begin errors++; $display("FAIL cks0_cmf: got %0b expected 0", CMF); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_cbr();
    test_pending_saturate();
    test_we_cmf();
    test_self_refresh();
    test_random_cbr();
    test_reset_mid_ras();
    test_random_timer();
    test_cks_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsc_rfsh_ctrl.md
BSC_RFSH_CTRL -- requirements
Module: bsc_rfsh_ctrl

Interface
REQ-001 The block SHALL have the following ports; reset RST_N is asynchronous, active-low, and the clock is CLK.
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; all state advances only when CE_R=1
- CKS  in  3  RTCSR clock select
- CMIE  in  1  compare-match interrupt enable
- RFSH  in  1  MCR refresh enable
- RMODE  in  1  MCR refresh mode: 0 = auto (CBR), 1 = self-refresh
- TRP  in  1  MCR RAS precharge: 0 = 1 cycle, 1 = 2 cycles
- TRAS  in  2  MCR RAS low time: TRAS+2 cycles
- RTCOR  in  8  compare value
- RTCNT_WE  in  1  RTCNT write strobe
- RTCNT_DI  in  8  RTCNT write data
- CMF_CLR  in  1  clear-CMF strobe
- RFSH_GNT  in  1  bus grant from the bus state controller (level)
- RTCNT  out  8  counter value
- CMF  out  1  compare-match flag
- IRQ  out  1  CMF & CMIE
- RFSH_REQ  out  1  refresh bus request
- RFSH_BUSY  out  1  refresh cycle owns the bus
- RFSH_RAS_N  out  1  refresh RAS strobe
- RFSH_CAS_N  out  1  refresh CAS strobe (all byte lanes)
- RFSH_DONE  out  1  one-CE_R pulse when a CBR cycle ends

Function
REQ-002 Prescaler: 12-bit counter; tick period selected by CKS: 001=4, 010=16, 011=64, 100=256, 101=1024, 110=2048, 111=4096 CE_R cycles; 000 SHALL hold the prescaler at 0 and produce no ticks.
REQ-003 A change of CKS SHALL clear the prescaler in the same CE_R cycle.
REQ-004 On a tick with RTCNT==RTCOR: RTCNT<=0 and CMF<=1; when RFSH=1 and RMODE=0, the pending count SHALL also increment.
REQ-005 On a tick without a match, RTCNT SHALL increment, wrapping FF->00 without setting any flag.
REQ-006 RTCNT_WE SHALL override the tick in the same cycle, and the compare SHALL be suppressed in that cycle.
REQ-007 CMF_CLR SHALL clear CMF; a simultaneous match SHALL win (CMF stays 1).
REQ-008 Pending count: 2 bits, saturating at 3. A simultaneous increment and grant-accept SHALL leave it unchanged. RFSH=0 SHALL clear it.
REQ-009 FSM states: IDLE, REQ, PRE, CAS, RAS, SELF, SEXIT.
REQ-010 IDLE->REQ when pending!=0 (auto mode), or when RFSH=1 & RMODE=1 (self-refresh mode).
REQ-011 RFSH_REQ SHALL be 1 only in REQ.
REQ-012 REQ->PRE when RFSH_GNT=1; in auto mode pending SHALL decrement at this point. RFSH_BUSY SHALL be 1 in every state except IDLE and REQ.
REQ-013 PRE: RAS_N=CAS_N=1 for TRP+1 cycles, then ->CAS.
REQ-014 CAS: CAS_N=0, RAS_N=1 for 1 cycle; then ->RAS in auto mode, ->SELF in self-refresh mode.
REQ-015 RAS: CAS_N=0, RAS_N=0 for TRAS+2 cycles; then ->IDLE with strobes high and RFSH_DONE=1 for that cycle.
REQ-016 SELF: RAS_N=CAS_N=0, held while RFSH=1 & RMODE=1; otherwise ->SEXIT.
REQ-017 SEXIT: strobes high for TRP+1 cycles, then ->IDLE.
REQ-018 RFSH or RMODE changing during PRE, CAS or RAS SHALL NOT abort the cycle; the cycle completes.
REQ-019 REQ with RFSH=0 SHALL return to IDLE without any bus cycle.
REQ-020 IRQ SHALL be combinational: CMF & CMIE.

Reset
REQ-021 On RST_N=0: prescaler=0, RTCNT=0, CMF=0, pending=0, state=IDLE, RFSH_REQ=0, RFSH_BUSY=0, RFSH_RAS_N=1, RFSH_CAS_N=1, RFSH_DONE=0, IRQ=0.
REQ-022 Assertion of reset mid-cycle SHALL release the strobes immediately (asynchronously).

Structure
REQ-023 The refresh FSM state enum and the CKS-to-divider constants SHALL live in SH7604_PKG.
REQ-024 The prescaler plus RTCNT/compare logic SHALL be one sub-module, rfsh_timer; the FSM and pending counter SHALL be in the top level.
REQ-025 The block SHALL contain no register-bus decode; register fields arrive as decoded ports.

Verification
REQ-026 CKS=001, RTCOR=02, RFSH=1, RMODE=0, GNT=1 -> CMF=1 at CE_R 12; RFSH_REQ for 1 cycle; RAS/CAS waveform with TRP=0, TRAS=0: PRE 1, CAS 1, RAS 2; DONE pulse.
REQ-027 GNT held 0 across 4 matches -> pending saturates at 3; then GNT=1 -> exactly 3 back-to-back CBR cycles.
REQ-028 RTCNT_WE with RTCNT_DI=RTCOR on a tick cycle -> no CMF; CMF_CLR on a match cycle -> CMF=1.
REQ-029 RMODE=1 -> REQ, PRE, CAS, SELF with strobes low; clear RMODE -> SEXIT for TRP+1 cycles, then IDLE with no DONE pulse.
REQ-030 RST_N=0 during RAS -> RAS_N=CAS_N=1 immediately; pending=0 after release.
REQ-031 CKS=000 for 10000 cycles -> RTCNT unchanged.
